// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between uart_rx and ram_rw.
// It absorbs receive bursts while the consumer is stalled.
// The push side has no stall, so a byte offered while full is dropped.
// A dropped byte sets a sticky overflow flag.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic [7:0]    in_data_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    output logic [7:0]    out_data_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [AW:0]   level_o,
    output logic          overflow_o
);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status and handshakes depend only on the pointers, so the ready/valid
    // outputs never see a combinational path from the opposite input.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        in_rdy_o   = !full;
        out_vld_o  = !empty;
        push       = in_vld_i && !full;
        pop        = out_rdy_i && !empty;
        level_o    = wr_ptr - rd_ptr;
        out_data_o = mem[rd_ptr[AW-1:0]];
    end

    // Pointer and overflow state. clr_i overrides any push, pop or overflow
    // event on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (in_vld_i && full)
                overflow_o <= 1'b1;
        end
    end

    // Storage array, left unreset. A write happens only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i)
            mem[wr_ptr[AW-1:0]] <= in_data_i;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       clr_i;
    logic [7:0] in_data_i;
    logic       in_vld_i;
    logic       in_rdy_o;
    logic [7:0] out_data_o;
    logic       out_vld_o;
    logic       out_rdy_i;
    logic [4:0] level_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (clr_i),
        .in_data_i  (in_data_i),
        .in_vld_i   (in_vld_i),
        .in_rdy_o   (in_rdy_o),
        .out_data_o (out_data_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_data_i = d;
        in_vld_i  = 1'b1;
        tick();
        in_vld_i  = 1'b0;
    endtask

    task automatic flush();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; clr_i = 1'b0; in_vld_i = 1'b0; in_data_i = 8'h00; out_rdy_i = 1'b0;
        tick();
        checks++;
        if (level_o !== 5'd0 || out_vld_o !== 1'b0 || in_rdy_o !== 1'b1 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: level=%0d vld=%b rdy=%b ovf=%b, want 0 0 1 0",
                     level_o, out_vld_o, in_rdy_o, overflow_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp[0] = 8'h2a; exp[1] = 8'h2c; exp[2] = 8'h00;
        for (int i = 0; i < 3; i++) push_byte(exp[i]);
        checks++;
        if (level_o !== 5'd3 || out_data_o !== 8'h2a) begin
            errors++;
            $display("FAIL basic_hold: level=%0d data=%h, want 3 2a", level_o, out_data_o);
        end
        out_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== exp[i]) begin
                errors++;
                $display("FAIL basic_pop%0d: vld=%b data=%h, want 1 %h", i, out_vld_o, out_data_o, exp[i]);
            end
            tick();
        end
        out_rdy_i = 1'b0;
        checks++;
        if (out_vld_o !== 1'b0 || level_o !== 5'd0) begin
            errors++;
            $display("FAIL basic_empty: vld=%b level=%0d, want 0 0", out_vld_o, level_o);
        end
    endtask

    task automatic test_latency();
        in_data_i = 8'h93;
        in_vld_i  = 1'b1;
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_pre: vld=%b, want 0", out_vld_o);
        end
        tick();
        in_vld_i = 1'b0;
        checks++;
        if (out_vld_o !== 1'b1 || out_data_o !== 8'h93) begin
            errors++;
            $display("FAIL latency_post: vld=%b data=%h, want 1 93", out_vld_o, out_data_o);
        end
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        checks++;
        if (level_o !== 5'd16 || in_rdy_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: level=%0d rdy=%b ovf=%b, want 16 0 0", level_o, in_rdy_o, overflow_o);
        end
        push_byte(8'hee);
        checks++;
        if (overflow_o !== 1'b1 || level_o !== 5'd16) begin
            errors++;
            $display("FAIL fill_ovf: ovf=%b level=%0d, want 1 16", overflow_o, level_o);
        end
        out_rdy_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 8'(i)) begin
                errors++;
                $display("FAIL fill_drain%0d: vld=%b data=%h, want 1 %h", i, out_vld_o, out_data_o, 8'(i));
            end
            tick();
        end
        out_rdy_i = 1'b0;
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_extra: vld=%b data=%h, want empty", out_vld_o, out_data_o);
        end
    endtask

    task automatic test_full_pop();
        flush();
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        in_data_i = 8'h55; in_vld_i = 1'b1; out_rdy_i = 1'b1;
        tick();
        in_vld_i = 1'b0; out_rdy_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1 || level_o !== 5'd15 || in_rdy_o !== 1'b1 || out_data_o !== 8'h11) begin
            errors++;
            $display("FAIL fullpop: ovf=%b level=%0d rdy=%b data=%h, want 1 15 1 11",
                     overflow_o, level_o, in_rdy_o, out_data_o);
        end
        push_byte(8'h55);
        checks++;
        if (level_o !== 5'd16) begin
            errors++;
            $display("FAIL fullpop_refill: level=%0d, want 16", level_o);
        end
        out_rdy_i = 1'b1;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] e;
            e = (i == 16) ? 8'h55 : 8'h10 + 8'(i);
            checks++;
            if (out_data_o !== e) begin
                errors++;
                $display("FAIL fullpop_drain%0d: data=%h, want %h", i, out_data_o, e);
            end
            tick();
        end
        out_rdy_i = 1'b0;
    endtask

    task automatic test_wrap();
        flush();
        out_rdy_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data_i = 8'(i);
            in_vld_i  = 1'b1;
            tick();
            checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 8'(i) || level_o !== 5'd1) begin
                errors++;
                $display("FAIL wrap%0d: vld=%b data=%h level=%0d, want 1 %h 1",
                         i, out_vld_o, out_data_o, level_o, 8'(i));
            end
        end
        in_vld_i = 1'b0;
        tick();
        out_rdy_i = 1'b0;
        checks++;
        if (level_o !== 5'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: level=%0d ovf=%b, want 0 0", level_o, overflow_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) push_byte(8'h40 + 8'(i));
        out_rdy_i = 1'b1;
        repeat (11) tick();
        out_rdy_i = 1'b0;
        checks++;
        if (level_o !== 5'd5 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: level=%0d ovf=%b, want 5 1", level_o, overflow_o);
        end
        clr_i = 1'b1; in_vld_i = 1'b1; in_data_i = 8'h77;
        tick();
        clr_i = 1'b0; in_vld_i = 1'b0;
        checks++;
        if (level_o !== 5'd0 || overflow_o !== 1'b0 || out_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL flush: level=%0d ovf=%b vld=%b, want 0 0 0", level_o, overflow_o, out_vld_o);
        end
        push_byte(8'h12);
        checks++;
        if (level_o !== 5'd1 || out_data_o !== 8'h12) begin
            errors++;
            $display("FAIL flush_after: level=%0d data=%h, want 1 12", level_o, out_data_o);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        in_vld_i = 1'b1; in_data_i = 8'hab;
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (level_o !== 5'd0 || out_vld_o !== 1'b0 || in_rdy_o !== 1'b1 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: level=%0d vld=%b rdy=%b ovf=%b, want 0 0 1 0",
                     level_o, out_vld_o, in_rdy_o, overflow_o);
        end
        in_vld_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        push_byte(8'h3c);
        checks++;
        if (level_o !== 5'd1 || out_data_o !== 8'h3c) begin
            errors++;
            $display("FAIL reset_mid_after: level=%0d data=%h, want 1 3c", level_o, out_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_fill();
        test_full_pop();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
